// File: rtl/opb_ppc2simulink_pkg.sv
// Shared definitions for the PPC-to-Simulink OPB register bank: FSM encoding,
// commit-bit position, counter width and the byte-lane merge helper.
package opb_ppc2simulink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // OPB bit 31 (IBM numbering) is bit 0 of the descending-range view used internally.
    localparam int COMMIT_BIT = 0;
    localparam int CNT_W      = 16;
    localparam int IDX_W      = 5;

    // Lane k of the descending view covers bits [8k+7:8k] and is enabled by be[k].
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_dat,
                                                input logic [31:0] new_dat,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_dat;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = new_dat[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle. Vectors use descending ranges: OPB bit n (IBM
// numbering, bit 0 = MSB) is bit [31-n] here, and OPB_BE[n] is OPB_BE[3-n].
interface opb_register_bank_ppc2simulink_if;
    logic [31:0] OPB_ABus;
    logic [3:0]  OPB_BE;
    logic [31:0] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [31:0] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_reg_bytewrite.sv
// One 32-bit register with byte-enable write merge; disabled lanes hold their value.
module opb_reg_bytewrite
    import opb_ppc2simulink_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdat_i,
    output logic [31:0] dat_o
);

    logic [31:0] dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= '0;
        end else if (wr_en_i) begin
            dat_q <= merge_bytes(dat_q, wdat_i, be_i);
        end
    end

    assign dat_o = dat_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank feeding Simulink user logic, optionally double-buffered
// behind a commit word that also carries a 16-bit commit counter.
module opb_register_bank_ppc2simulink
    import opb_ppc2simulink_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01001000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010010FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter int          C_DOUBLE_BUF = 1,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst,
    opb_register_bank_ppc2simulink_if.slave bus,
    output logic [C_NUM_REGS*32-1:0]     user_data_out,
    output logic [C_NUM_REGS-1:0]        user_wr_strb
);

    localparam logic [31:0]      SPAN_BYTES = 32'(4 * (C_NUM_REGS + 1));
    localparam logic [IDX_W-1:0] CMT_IDX    = IDX_W'(C_NUM_REGS);
    localparam int unused_family_bits = $bits(C_FAMILY);

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [C_OPB_DWIDTH-1:0] wdat;
    logic [31:0]             offset;
    logic [IDX_W-1:0]        idx;
    logic                    hit;
    logic [31:0]             rd_dat;

    state_t            state_q;
    logic              ack_q;
    logic [31:0]       sl_dbus_q;
    logic [IDX_W-1:0]  req_idx_q;
    logic              req_rnw_q;
    logic [3:0]        req_be_q;
    logic [31:0]       req_dat_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [C_NUM_REGS-1:0] strb_q;
    logic [C_NUM_REGS-1:0] wr_en;
    logic [31:0]       store [C_NUM_REGS];
    logic              acc_wr;
    logic              commit;
    logic              unused_ok;

    assign addr   = bus.OPB_ABus;
    assign wdat   = bus.OPB_DBus;
    assign offset = 32'(addr) - C_BASEADDR;
    assign idx    = offset[IDX_W+1:2];
    assign hit    = bus.OPB_select && (32'(addr) >= C_BASEADDR) &&
                    (offset < SPAN_BYTES) && (32'(addr) <= C_HIGHADDR);

    always_comb begin
        rd_dat = '0;
        if (idx == CMT_IDX) rd_dat = {{(32-CNT_W){1'b0}}, cnt_q};
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) rd_dat = store[i];
        end
    end

    // The request is captured on the hit edge; its side effects land at the end of ACK.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            sl_dbus_q <= '0;
            req_idx_q <= '0;
            req_rnw_q <= 1'b0;
            req_be_q  <= '0;
            req_dat_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        state_q   <= ST_ACK;
                        ack_q     <= 1'b1;
                        sl_dbus_q <= bus.OPB_RNW ? rd_dat : 32'h0;
                        req_idx_q <= idx;
                        req_rnw_q <= bus.OPB_RNW;
                        req_be_q  <= bus.OPB_BE;
                        req_dat_q <= 32'(wdat);
                    end
                end
                ST_ACK: begin
                    state_q   <= ST_HOLD;
                    ack_q     <= 1'b0;
                    sl_dbus_q <= '0;
                end
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ack_q     <= 1'b0;
                    sl_dbus_q <= '0;
                end
            endcase
        end
    end

    assign acc_wr = (state_q == ST_ACK) && !req_rnw_q;
    assign commit = acc_wr && (req_idx_q == CMT_IDX) && req_be_q[0] && req_dat_q[COMMIT_BIT];
    assign cnt_d  = commit ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        assign wr_en[i] = acc_wr && (req_idx_q == IDX_W'(i));
        opb_reg_bytewrite u_reg (
            .clk     (OPB_Clk),
            .rst     (OPB_Rst),
            .wr_en_i (wr_en[i]),
            .be_i    (req_be_q),
            .wdat_i  (req_dat_q),
            .dat_o   (store[i])
        );
    end

    if (C_DOUBLE_BUF != 0) begin : g_dbuf
        logic [31:0] active_q [C_NUM_REGS];

        // Strobe only the registers whose committed value actually moves.
        always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
            if (OPB_Rst) begin
                for (int i = 0; i < C_NUM_REGS; i++) active_q[i] <= '0;
                strb_q <= '0;
            end else begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    strb_q[i] <= commit && (active_q[i] != store[i]);
                    if (commit) active_q[i] <= store[i];
                end
            end
        end

        for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
            assign user_data_out[32*i +: 32] = active_q[i];
        end
    end else begin : g_direct
        always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
            if (OPB_Rst) strb_q <= '0;
            else         strb_q <= wr_en;
        end

        for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
            assign user_data_out[32*i +: 32] = store[i];
        end
    end

    assign user_wr_strb   = strb_q;
    assign bus.Sl_DBus    = sl_dbus_q;
    assign bus.Sl_xferAck = ack_q;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;
    assign unused_ok      = &{1'b0, bus.OPB_seqAddr};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: directed vector table, reset-in-ACK sequence,
// randomized traffic against an array model, and commit-counter wrap.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01001000;
    localparam logic [31:0] HIGH = 32'h010010FF;
    localparam int          NREG = 8;

    logic clk;
    logic rst;
    logic [NREG*32-1:0] user_data_out;
    logic [NREG-1:0]    user_wr_strb;

    opb_register_bank_ppc2simulink_if bus ();

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (NREG),
        .C_DOUBLE_BUF (1),
        .C_FAMILY     ("virtex5")
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .bus           (bus),
        .user_data_out (user_data_out),
        .user_wr_strb  (user_wr_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // One complete transfer; returns what was seen in the ACK cycle, the HOLD cycle and the following IDLE cycle.
    task automatic xfer(input logic [31:0] a, input bit sel, input bit rnw, input logic [3:0] be,
                        input logic [31:0] d, output bit ack, output logic [31:0] rd,
                        output logic [NREG-1:0] strb, output logic [NREG*32-1:0] udo,
                        output logic [NREG-1:0] strb_after);
        @(negedge clk);
        bus.OPB_ABus = a; bus.OPB_select = sel; bus.OPB_RNW = rnw; bus.OPB_BE = be; bus.OPB_DBus = d;
        @(posedge clk); #1;
        ack = bus.Sl_xferAck; rd = bus.Sl_DBus;
        @(negedge clk);
        bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0; bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        @(posedge clk); #1;
        strb = user_wr_strb; udo = user_data_out;
        @(posedge clk); #1;
        strb_after = user_wr_strb;
    endtask

    // Reference model: byte lanes in OPB numbering, lane 0 = most significant.
    logic [31:0] m_shadow [NREG];
    logic [31:0] m_active [NREG];
    logic [15:0] m_cnt;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
        m_cnt = '0;
    endtask

    task automatic model_xfer(input string tag, input logic [31:0] a, input bit sel, input bit rnw,
                              input logic [3:0] be, input logic [31:0] d);
        bit hit;
        int idx;
        bit ack;
        logic [31:0] rd, exp_rd;
        logic [NREG-1:0] strb, strb_after, exp_strb;
        logic [NREG*32-1:0] udo, exp_udo;
        hit = sel && (a >= BASE) && (a <= HIGH) && ((a - BASE) / 4 <= NREG);
        idx = hit ? int'((a - BASE) / 4) : -1;
        exp_rd = '0;
        exp_strb = '0;
        if (hit && rnw) exp_rd = (idx == NREG) ? {16'h0, m_cnt} : m_shadow[idx];
        if (hit && !rnw) begin
            if (idx < NREG) begin
                for (int k = 0; k < 4; k++)
                    if (be[3-k]) m_shadow[idx][31-8*k -: 8] = d[31-8*k -: 8];
            end else if (be[0] && d[0]) begin
                m_cnt = m_cnt + 16'd1;
                for (int i = 0; i < NREG; i++) begin
                    if (m_active[i] != m_shadow[i]) exp_strb[i] = 1'b1;
                    m_active[i] = m_shadow[i];
                end
            end
        end
        for (int i = 0; i < NREG; i++) exp_udo[32*i +: 32] = m_active[i];
        xfer(a, sel, rnw, be, d, ack, rd, strb, udo, strb_after);
        chk({tag, " ack"}, 256'(ack), 256'(hit));
        chk({tag, " rdata"}, 256'(rd), 256'(exp_rd));
        chk({tag, " strb"}, 256'(strb), 256'(exp_strb));
        chk({tag, " user_data"}, 256'(udo), 256'(exp_udo));
        chk({tag, " strb_after"}, 256'(strb_after), 256'(0));
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          sel;
        bit          rnw;
        logic [3:0]  be;
        logic [31:0] dat;
        bit          e_ack;
        logic [31:0] e_rd;
        logic [7:0]  e_strb;
        logic [31:0] e_u2;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input bit s, input bit r, input logic [3:0] b,
                                input logic [31:0] d, input bit ea, input logic [31:0] er,
                                input logic [7:0] es, input logic [31:0] eu);
        vec_t v;
        v.addr = a; v.sel = s; v.rnw = r; v.be = b; v.dat = d;
        v.e_ack = ea; v.e_rd = er; v.e_strb = es; v.e_u2 = eu;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        bit ack;
        logic [31:0] rd;
        logic [NREG-1:0] strb, strb_after;
        logic [NREG*32-1:0] udo;

        vt[0]  = mk(BASE + 32'h08, 1, 0, 4'hF,    32'hDEADBEEF, 1, 32'h0,        8'h00, 32'h0);
        vt[1]  = mk(BASE + 32'h08, 1, 1, 4'hF,    32'h0,        1, 32'hDEADBEEF, 8'h00, 32'h0);
        vt[2]  = mk(BASE + 32'h20, 1, 0, 4'hF,    32'h00000001, 1, 32'h0,        8'h04, 32'hDEADBEEF);
        vt[3]  = mk(BASE + 32'h20, 1, 1, 4'hF,    32'h0,        1, 32'h00000001, 8'h00, 32'hDEADBEEF);
        vt[4]  = mk(BASE + 32'h08, 1, 0, 4'b0100, 32'h11223344, 1, 32'h0,        8'h00, 32'hDEADBEEF);
        vt[5]  = mk(BASE + 32'h08, 1, 1, 4'hF,    32'h0,        1, 32'hDE22BEEF, 8'h00, 32'hDEADBEEF);
        vt[6]  = mk(BASE + 32'h80, 1, 0, 4'hF,    32'hCAFEF00D, 0, 32'h0,        8'h00, 32'hDEADBEEF);
        vt[7]  = mk(BASE + 32'h80, 1, 1, 4'hF,    32'h0,        0, 32'h0,        8'h00, 32'hDEADBEEF);
        vt[8]  = mk(BASE + 32'h20, 1, 0, 4'b1110, 32'hFFFFFFFF, 1, 32'h0,        8'h00, 32'hDEADBEEF);
        vt[9]  = mk(BASE + 32'h20, 1, 1, 4'hF,    32'h0,        1, 32'h00000001, 8'h00, 32'hDEADBEEF);
        vt[10] = mk(BASE + 32'h20, 1, 0, 4'hF,    32'h00000001, 1, 32'h0,        8'h04, 32'hDE22BEEF);
        vt[11] = mk(BASE + 32'h20, 1, 1, 4'hF,    32'h0,        1, 32'h00000002, 8'h00, 32'hDE22BEEF);
        vt[12] = mk(BASE + 32'h1C, 1, 1, 4'hF,    32'h0,        1, 32'h0,        8'h00, 32'hDE22BEEF);
        vt[13] = mk(BASE - 32'h04, 1, 1, 4'hF,    32'h0,        0, 32'h0,        8'h00, 32'hDE22BEEF);
        vt[14] = mk(BASE + 32'h08, 0, 1, 4'hF,    32'h0,        0, 32'h0,        8'h00, 32'hDE22BEEF);

        rst = 1'b1;
        bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ack", 256'(bus.Sl_xferAck), 256'(0));
        chk("reset dbus", 256'(bus.Sl_DBus), 256'(0));
        chk("reset user_data", 256'(user_data_out), 256'(0));
        chk("reset strb", 256'(user_wr_strb), 256'(0));
        chk("tied outputs", 256'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), 256'(0));
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            xfer(vt[i].addr, vt[i].sel, vt[i].rnw, vt[i].be, vt[i].dat, ack, rd, strb, udo, strb_after);
            chk($sformatf("vec%0d ack", i), 256'(ack), 256'(vt[i].e_ack));
            chk($sformatf("vec%0d rdata", i), 256'(rd), 256'(vt[i].e_rd));
            chk($sformatf("vec%0d strb", i), 256'(strb), 256'(vt[i].e_strb));
            chk($sformatf("vec%0d reg2_out", i), 256'(udo[95:64]), 256'(vt[i].e_u2));
            chk($sformatf("vec%0d strb_after", i), 256'(strb_after), 256'(0));
        end

        // Reset while the write to reg 3 is being acknowledged.
        @(negedge clk);
        bus.OPB_ABus = BASE + 32'h0C; bus.OPB_select = 1'b1; bus.OPB_RNW = 1'b0;
        bus.OPB_BE = 4'hF; bus.OPB_DBus = 32'hAAAA5555;
        @(posedge clk); #1;
        chk("rst_mid ack before", 256'(bus.Sl_xferAck), 256'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_mid ack", 256'(bus.Sl_xferAck), 256'(0));
        chk("rst_mid dbus", 256'(bus.Sl_DBus), 256'(0));
        chk("rst_mid user_data", 256'(user_data_out), 256'(0));
        chk("rst_mid strb", 256'(user_wr_strb), 256'(0));
        @(negedge clk);
        bus.OPB_select = 1'b0; bus.OPB_ABus = '0; bus.OPB_DBus = '0;
        rst = 1'b0;
        model_reset();
        model_xfer("post_rst reg3", BASE + 32'h0C, 1, 1, 4'hF, 32'h0);
        model_xfer("post_rst status", BASE + 32'h20, 1, 1, 4'hF, 32'h0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a, d;
            int k;
            bit sel, rnw;
            logic [3:0] be;
            k   = $urandom_range(0, NREG + 3);
            a   = ($urandom_range(0, 15) == 0) ? BASE - 32'h4 : BASE + 32'(4 * k);
            sel = ($urandom_range(0, 9) != 0);
            rnw = 1'($urandom_range(0, 1));
            be  = 4'($urandom_range(0, 15));
            d   = $urandom;
            if (k == NREG && $urandom_range(0, 1) == 1) begin be[0] = 1'b1; d[0] = 1'b1; end
            model_xfer($sformatf("rand%0d", n), a, sel, rnw, be, d);
        end

        // Counter wrap: start just below 0xFFFF.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        model_xfer("wrap read FFFE", BASE + 32'h20, 1, 1, 4'hF, 32'h0);
        model_xfer("wrap commit1", BASE + 32'h20, 1, 0, 4'hF, 32'h00000001);
        model_xfer("wrap read FFFF", BASE + 32'h20, 1, 1, 4'hF, 32'h0);
        model_xfer("wrap commit2", BASE + 32'h20, 1, 0, 4'hF, 32'h00000001);
        model_xfer("wrap read 0000", BASE + 32'h20, 1, 1, 4'hF, 32'h0);
        chk("wrap model zero", 256'(m_cnt), 256'(0));
        model_xfer("wrap commit3", BASE + 32'h20, 1, 0, 4'hF, 32'h00000001);
        model_xfer("wrap read 0001", BASE + 32'h20, 1, 1, 4'hF, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
